freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/edge_sync.sv | 35 +++
 rtl/freq_meter.sv | 140 ++++++++++++++
 tb/tb_freq_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and defaults for the frequency meter
// Contents: FSM state encoding and default parameter values.
package freq_meter_pkg;

    localparam int GATE_CYCLES_DEF = 50000;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } fm_state_e;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with registered rising-edge tick
// Ports:
//   clk_in  - sampling clock
//   rst_n   - asynchronous active-low reset
//   async_i - asynchronous level input (signal, push-button, ...)
//   tick_o  - one-cycle pulse per synchronized rising edge, 3 cycles after the rise
module edge_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_i,
    output logic tick_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sync2_q & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts rising edges of an async signal over a fixed gate window
// Ports:
//   clk_in    - system clock
//   rst_n     - asynchronous active-low reset
//   sig_in    - signal being measured, asynchronous to clk_in
//   meas_en   - level enable; high runs back-to-back windows
//   sig_tick  - one-cycle pulse per synchronized rising edge of sig_in
//   count_out - edge count of the last completed window, held between windows
//   valid     - one-cycle strobe when count_out updates
//   overflow  - last completed window saturated the edge counter
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic             sig_tick,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow
);

    localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic tick;

    fm_state_e         state_q, state_d;
    logic [GW-1:0]     gate_q,  gate_d;
    logic [CNT_W-1:0]  edge_q,  edge_d;
    logic              sat_q,   sat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q,   ovf_d;
    logic              valid_q, valid_d;

    // Edge counter value including this cycle's tick, saturating at CNT_MAX.
    logic [CNT_W-1:0]  edge_inc;
    logic              sat_inc;

    edge_sync u_edge_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .async_i (sig_in),
        .tick_o  (tick)
    );

    always_comb begin
        edge_inc = edge_q;
        sat_inc  = sat_q;
        if (tick) begin
            if (edge_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                edge_inc = edge_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (meas_en) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                gate_d  = '0;
                edge_d  = '0;
                sat_d   = 1'b0;
                state_d = ST_GATE;
            end
            ST_GATE: begin
                if (!meas_en) begin
                    // Abort: results of the partial window are discarded.
                    state_d = ST_IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Last cycle's tick belongs to the ending window; the new
                    // window starts from 0 on the next cycle with no dead time.
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                    count_d = edge_inc;
                    ovf_d   = sat_inc;
                    valid_d = 1'b1;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = edge_inc;
                    sat_d  = sat_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign sig_tick  = tick;
    assign count_out = count_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int CW   = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          meas_en;
    logic          sig_tick;
    logic [CW-1:0] count_out;
    logic          valid;
    logic          overflow;
    logic          sig_in;

    int   errors = 0;
    int   checks = 0;

    // sig_in source: free-running square wave when sig_half > 0, else man_sig.
    int   sig_half = 0;
    int   ph       = 0;
    logic gen_sig  = 1'b0;
    logic man_sig  = 1'b0;

    assign sig_in = (sig_half > 0) ? gen_sig : man_sig;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        #1;
        if (sig_half > 0) begin
            ph = ph + 1;
            if (ph >= sig_half) begin
                ph      = 0;
                gen_sig = ~gen_sig;
            end
        end
    end

    freq_meter #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CW)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .meas_en   (meas_en),
        .sig_tick  (sig_tick),
        .count_out (count_out),
        .valid     (valid),
        .overflow  (overflow)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk_in);
            cyc++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int vcount;
        rst_n   = 1'b0;
        meas_en = 1'b0;
        man_sig = 1'b0;
        step(2);
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (sig_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", sig_tick); end
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (valid === 1'b1) vcount++;
        end
        checks++; if (vcount != 0) begin errors++; $display("FAIL reset_idle_valid got=%0d exp=0", vcount); end
    endtask

    task automatic test_steady;
        int cyc;
        bit ok;
        sig_half = 5;
        step(20);
        meas_en = 1'b1;
        wait_valid(200, cyc, ok);
        checks++; if (!ok || cyc != GATE + 2) begin errors++; $display("FAIL steady_first_latency got=%0d exp=%0d", cyc, GATE + 2); end
        checks++; if (count_out !== 4'd10) begin errors++; $display("FAIL steady_first_count got=%0d exp=10", count_out); end
        for (int w = 0; w < 3; w++) begin
            wait_valid(150, cyc, ok);
            checks++; if (!ok || cyc != GATE) begin errors++; $display("FAIL steady_spacing w=%0d got=%0d exp=%0d", w, cyc, GATE); end
            checks++; if (count_out !== 4'd10 || overflow !== 1'b0) begin
                errors++; $display("FAIL steady_count w=%0d got=%0d/%b exp=10/0", w, count_out, overflow);
            end
        end
    endtask

    task automatic test_saturation;
        int cyc;
        bit ok;
        sig_half = 2;
        wait_valid(150, cyc, ok);
        wait_valid(150, cyc, ok);
        checks++; if (!ok || count_out !== 4'd15 || overflow !== 1'b1) begin
            errors++; $display("FAIL sat_count got=%0d/%b exp=15/1", count_out, overflow);
        end
        sig_half = 10;
        wait_valid(150, cyc, ok);
        wait_valid(150, cyc, ok);
        checks++; if (!ok || count_out !== 4'd5 || overflow !== 1'b0) begin
            errors++; $display("FAIL slow_count got=%0d/%b exp=5/0", count_out, overflow);
        end
    endtask

    task automatic test_abort;
        int cyc;
        bit ok;
        int vcount;
        // Currently in the first cycle of a window (gate count 0).
        step(50);
        meas_en = 1'b0;
        vcount = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (valid === 1'b1) vcount++;
        end
        checks++; if (vcount != 0) begin errors++; $display("FAIL abort_valid got=%0d exp=0", vcount); end
        checks++; if (count_out !== 4'd5 || overflow !== 1'b0) begin
            errors++; $display("FAIL abort_hold got=%0d/%b exp=5/0", count_out, overflow);
        end
        meas_en = 1'b1;
        wait_valid(300, cyc, ok);
        checks++; if (!ok || cyc != GATE + 2) begin errors++; $display("FAIL rearm_latency got=%0d exp=%0d", cyc, GATE + 2); end
        checks++; if (count_out !== 4'd5) begin errors++; $display("FAIL rearm_count got=%0d exp=5", count_out); end
    endtask

    task automatic test_boundary;
        int cyc;
        bit ok;
        sig_half = 0;
        man_sig  = 1'b0;
        wait_valid(150, cyc, ok);
        wait_valid(150, cyc, ok);
        checks++; if (!ok || count_out !== 4'd0) begin errors++; $display("FAIL quiet_count got=%0d exp=0", count_out); end
        // Window A: a rise at gate 96 ticks at gate 99.
        step(96);
        man_sig = 1'b1;
        step(2);
        man_sig = 1'b0;
        step(1);
        checks++; if (sig_tick !== 1'b1) begin errors++; $display("FAIL tick_at_99 got=%b exp=1", sig_tick); end
        step(1);
        checks++; if (valid !== 1'b1 || count_out !== 4'd1) begin
            errors++; $display("FAIL last_cycle_edge got=%b/%0d exp=1/1", valid, count_out);
        end
        // Window B: a rise at gate 97 ticks at gate 0 of window C.
        step(97);
        man_sig = 1'b1;
        step(2);
        man_sig = 1'b0;
        step(1);
        checks++; if (valid !== 1'b1 || count_out !== 4'd0 || sig_tick !== 1'b1) begin
            errors++; $display("FAIL window_b got=%b/%0d tick=%b exp=1/0 tick=1", valid, count_out, sig_tick);
        end
        step(100);
        checks++; if (valid !== 1'b1 || count_out !== 4'd1) begin
            errors++; $display("FAIL first_cycle_edge got=%b/%0d exp=1/1", valid, count_out);
        end
    endtask

    task automatic test_glitch_latency;
        man_sig = 1'b1;
        step(1);
        man_sig = 1'b0;
        step(6);
        man_sig = 1'b1;
        step(1);
        checks++; if (sig_tick !== 1'b0) begin errors++; $display("FAIL latency_c1 got=%b exp=0", sig_tick); end
        step(1);
        checks++; if (sig_tick !== 1'b0) begin errors++; $display("FAIL latency_c2 got=%b exp=0", sig_tick); end
        step(1);
        man_sig = 1'b0;
        checks++; if (sig_tick !== 1'b1) begin errors++; $display("FAIL latency_c3 got=%b exp=1", sig_tick); end
        step(1);
        checks++; if (sig_tick !== 1'b0) begin errors++; $display("FAIL latency_c4 got=%b exp=0", sig_tick); end
    endtask

    task automatic test_reset_midwindow;
        int cyc;
        bit ok;
        int vcount;
        wait_valid(150, cyc, ok);
        for (int i = 0; i < 7; i++) begin
            man_sig = 1'b1;
            step(4);
            man_sig = 1'b0;
            step(4);
        end
        wait_valid(150, cyc, ok);
        checks++; if (!ok || count_out !== 4'd7) begin errors++; $display("FAIL seven_count got=%0d exp=7", count_out); end
        step(30);
        man_sig = 1'b1;
        step(3);
        rst_n   = 1'b0;
        meas_en = 1'b0;
        #1;
        checks++; if (count_out !== 4'd0 || valid !== 1'b0 || overflow !== 1'b0 || sig_tick !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%0d/%b/%b/%b exp=0/0/0/0", count_out, valid, overflow, sig_tick);
        end
        step(3);
        rst_n   = 1'b1;
        man_sig = 1'b0;
        vcount  = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_in);
            man_sig = (i % 8) < 4;
            if (valid === 1'b1) vcount++;
        end
        checks++; if (vcount != 0 || count_out !== 4'd0) begin
            errors++; $display("FAIL post_reset_idle got=%0d/%0d exp=0/0", vcount, count_out);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_saturation();
        test_abort();
        test_boundary();
        test_glitch_latency();
        test_reset_midwindow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
